ik_swift_avalon_bridge: RTL and testbench
=========================================

# ik_swift_avalon_bridge

Avalon-MM slave that sits between the HPS lightweight bus and the ik_swift accelerator core. It stages 36-bit fixed-point operands arriving as 32-bit bus halves into the core's input bundle, then sequences the core through reset and a fixed-length enable window. It captures the resulting joint deltas into read-back registers. It is the software-facing initiator/loader for the ik_swift interface.

## Interface
- WORD_W, 36: fixed-point word width of every core operand.
- RUN_CYCLES, 64: number of cycles core_en is held high per run; legal range 1..65535.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- chipselect  input  1  Avalon slave select.
- write  input  1  write strobe; qualified by chipselect.
- read  input  1  read strobe; qualified by chipselect.
- address  input  7  word address, map below.
- writedata  input  32  write data.
- readdata  output  32  read data, registered.
- core_en  output  1  core enable.
- core_rst  output  1  core synchronous reset pulse.
- z  output  3x36  base joint axis.
- joint_type  output  6  bit j set = joint j prismatic.
- dh_param  output  6x4x36  DH parameters, joint-major.
- target  output  6x36  target pose.
- delta  input  6x36  core delta outputs.

## Operation
- Operand word index w in 0..38; LO half at address 2w (bits 31:0), HI half at 2w+1 (bits 35:32 in writedata[3:0]).
- w 0..23 = dh_param[w/4][w%4]; w 24..29 = target[w-24]; w 30..32 = z[w-30]; w 33..38 = captured delta[w-33] (read-only; writes ignored).
- LO write loads a single shared 32-bit staging register. HI write commits {writedata[3:0], staging} atomically to word w; a HI write without a prior LO write commits the current staging value.
- Address 80 (CTRL, write): bit0 = start, bit1 = clear done. Both are self-clearing.
- Address 81 (STATUS, read): bit0 busy, bit1 done.
- Address 82 (JTYPE, R/W): bits 5:0 = joint_type.
- Unmapped reads return 0. Unmapped writes are ignored.
- FSM states:
  - IDLE: on start, clear done and go to CRST.
  - CRST: core_rst=1 for exactly 1 cycle, then go to RUN.
  - RUN: core_en=1; a 16-bit counter counts from 0 to RUN_CYCLES-1, then goes to CAP.
  - CAP: latch all six delta words, set done, return to IDLE.
- busy = (state != IDLE).
- While busy:
  - writes to operand words and JTYPE are dropped.
  - start is ignored.
  - clear done is honoured.
- Reads are always allowed.
- HI-half reads return {28'b0, bits 35:32}.
- Simultaneous start and clear in one write: clear applies, then the run starts; done ends up 0.

## Timing
- Reset values: readdata=0, core_en=0, core_rst=0, all operand registers=0, joint_type=0, captured delta=0, staging=0, done=0, state=IDLE.
- Read latency 1: readdata is valid on the cycle after chipselect&&read and holds until the next read. No waitrequest.
- Write takes effect on the edge where chipselect&&write is sampled.
- Start at edge N:
  - core_rst high in cycle N+1.
  - core_en high in cycles N+2 .. N+1+RUN_CYCLES.
  - delta sampled in cycle N+2+RUN_CYCLES.
  - done=1 and busy=0 visible from N+3+RUN_CYCLES.
- Asserting rst_n low mid-run:
  - immediately drops core_en and core_rst.
  - returns to IDLE and clears all registers.
- Core outputs are combinational from registers; no glitches beyond register transitions.

## Configuration
- IK_SWIFT_BRIDGE_DH_UPDATE_EN defined: in CAP, for each joint j, delta[j] is added (36-bit two's-complement wrap) to dh_param[j][0] if joint_type[j]=0, else to dh_param[j][1]. This closes the iteration loop in hardware; successive starts converge without software rewrite.
- Undefined: dh_param changes only via bus writes.
- Delta capture is identical in both builds.

## Test plan
- Reset then read addresses 0, 1, 66, 81 -> readdata 0 on each following cycle; core_en=0, core_rst=0.
- Write LO 0xDEADBEEF then HI 0x5 to w=24 (addresses 48, 49) -> target[0]=36'h5DEADBEEF; read 48/49 -> 0xDEADBEEF / 0x00000005; target[0] unchanged after the LO write alone.
- Start with RUN_CYCLES=4, core delta[2] tied to 36'h0_0000_0010 -> core_rst for 1 cycle, core_en for exactly 4 cycles, then STATUS=0x2 and read w=35 LO=0x10.
- Write to w=0 and a second start while busy -> dh_param[0][0] unchanged, exactly one run observed; CTRL clear while busy -> done=0 after completion is not forced.
- rst_n low at cycle 2 of RUN -> core_en falls asynchronously, STATUS=0, all operands 0.
- With IK_SWIFT_BRIDGE_DH_UPDATE_EN, joint_type=6'b000010, dh_param[1][1]=36'hFFFFFFFFF, delta[1]=1 -> dh_param[1][1]=0 after the run; dh_param[0][0] += delta[0].

Source files
------------

// File: rtl/ik_swift_avalon_bridge.sv
// ik_swift_avalon_bridge: Avalon-MM slave that loads ik_swift core operands
// from 32-bit bus halves, sequences the core through a reset pulse and a
// fixed-length enable window, and captures the joint deltas for read-back.
// Optional build macro: IK_SWIFT_BRIDGE_DH_UPDATE_EN (feeds each captured delta
// back into its joint's DH parameter at the end of a run).
module ik_swift_avalon_bridge #(
    parameter int WORD_W     = 36,
    parameter int RUN_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           chipselect,
    input  logic                           write,
    input  logic                           read,
    input  logic [6:0]                     address,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    readdata,
    output logic                           core_en,
    output logic                           core_rst,
    output logic [2:0][WORD_W-1:0]         z,
    output logic [5:0]                     joint_type,
    output logic [5:0][3:0][WORD_W-1:0]    dh_param,
    output logic [5:0][WORD_W-1:0]         target,
    input  logic [5:0][WORD_W-1:0]         delta
);

    localparam int          HI_W   = WORD_W - 32;
    localparam int          NWORDS = 39;          // 33 writable + 6 captured deltas
    localparam logic [15:0] LAST   = 16'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CRST, S_RUN, S_CAP} state_t;

    state_t                        state_q;
    logic [15:0]                   cnt_q;
    logic                          core_en_q, core_rst_q, done_q;
    logic [NWORDS-1:0][WORD_W-1:0] word_q;
    logic [31:0]                   stage_q;
    logic [5:0]                    jtype_q;
    logic [31:0]                   rdata_q;

    logic        wr, rd, busy, is_op, hi;
    logic [5:0]  w;
    logic        lo_wr, hi_wr, jt_wr, start, clr;
    logic [31:0] rd_d;

    // Bus decode: operand and JTYPE writes are locked out while a run is active
    always_comb begin
        wr    = chipselect & write;
        rd    = chipselect & read;
        busy  = (state_q != S_IDLE);
        is_op = (address < 7'd78);
        w     = address[6:1];
        hi    = address[0];
        lo_wr = wr & is_op & ~busy & ~hi & (w < 6'd33);
        hi_wr = wr & is_op & ~busy &  hi & (w < 6'd33);
        jt_wr = wr & (address == 7'd82) & ~busy;
        start = wr & (address == 7'd80) & writedata[0];
        clr   = wr & (address == 7'd80) & writedata[1];
    end

    // Read mux; HI halves return only the top bits of the word, zero-extended
    always_comb begin
        rd_d = '0;
        if (is_op) begin
            if (hi) rd_d = {{(32-HI_W){1'b0}}, word_q[w][WORD_W-1:32]};
            else    rd_d = word_q[w][31:0];
        end else if (address == 7'd81) begin
            rd_d = {30'b0, done_q, busy};
        end else if (address == 7'd82) begin
            rd_d = {26'b0, jtype_q};
        end
    end

    // Run sequencer: reset pulse, RUN_CYCLES of enable, one capture cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            core_en_q  <= 1'b0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // clear is honoured in any state; the capture cycle sets done last
            if (clr) done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        done_q     <= 1'b0;
                        core_rst_q <= 1'b1;
                        state_q    <= S_CRST;
                    end
                end
                S_CRST: begin
                    core_rst_q <= 1'b0;
                    core_en_q  <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    if (cnt_q == LAST) begin
                        core_en_q <= 1'b0;
                        state_q   <= S_CAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_CAP: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Operand store, staging half, joint type, delta capture and read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            stage_q <= '0;
            jtype_q <= '0;
            rdata_q <= '0;
        end else begin
            if (lo_wr) stage_q   <= writedata;
            if (hi_wr) word_q[w] <= {writedata[HI_W-1:0], stage_q};
            if (jt_wr) jtype_q   <= writedata[5:0];
            if (rd)    rdata_q   <= rd_d;
            // bus writes cannot collide with capture: both are gated by busy
            if (state_q == S_CAP) begin
                for (int j = 0; j < 6; j++) begin
                    word_q[33+j] <= delta[j];
`ifdef IK_SWIFT_BRIDGE_DH_UPDATE_EN
                    // revolute joints adjust theta (slot 0), prismatic adjust d (slot 1)
                    word_q[j*4 + (jtype_q[j] ? 1 : 0)] <=
                        word_q[j*4 + (jtype_q[j] ? 1 : 0)] + delta[j];
`endif
                end
            end
        end
    end

    // Core-facing bundle is a direct view of the operand store
    for (genvar j = 0; j < 6; j++) begin : g_joint
        for (genvar k = 0; k < 4; k++) begin : g_param
            assign dh_param[j][k] = word_q[j*4+k];
        end
        assign target[j] = word_q[24+j];
    end
    for (genvar i = 0; i < 3; i++) begin : g_axis
        assign z[i] = word_q[30+i];
    end

    assign joint_type = jtype_q;
    assign readdata   = rdata_q;
    assign core_en    = core_en_q;
    assign core_rst   = core_rst_q;

endmodule

// File: tb/tb_ik_swift_avalon_bridge.sv
// Scoreboard bench for ik_swift_avalon_bridge: reads push expected data from a
// register-map model; a negedge monitor pops and compares readdata and checks
// the core_rst/core_en windows of the most recent accepted run.
module tb_ik_swift_avalon_bridge;
    localparam int RC = 4;

    logic        clk = 0, rst_n = 0, cs = 0, wr = 0, rd = 0;
    logic [6:0]  addr = 0;
    logic [31:0] wdata = 0;
    logic [31:0] readdata;
    logic        core_en, core_rst;
    logic [2:0][35:0]      z;
    logic [5:0]            joint_type;
    logic [5:0][3:0][35:0] dh_param;
    logic [5:0][35:0]      target;
    logic [5:0][35:0]      delta_tb = '0;

    ik_swift_avalon_bridge #(.WORD_W(36), .RUN_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .chipselect(cs), .write(wr), .read(rd),
        .address(addr), .writedata(wdata), .readdata(readdata),
        .core_en(core_en), .core_rst(core_rst), .z(z), .joint_type(joint_type),
        .dh_param(dh_param), .target(target), .delta(delta_tb));

    always #5 clk = ~clk;

    // edge index: after posedge k, ecnt == k
    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    logic rdv;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) rdv <= 1'b0; else rdv <= cs && rd;

    // ---------------- reference model ----------------
    logic [35:0]      mem [0:38];
    logic [31:0]      stg;
    logic [5:0]       jt;
    logic             done_m;
    bit               pend, have_run;
    int               S;
    logic [5:0][35:0] snap;
    logic [31:0]      expq [$];
    int               n_chk = 0, n_fail = 0;
    int               en_cnt = 0, rst_cnt = 0;

    function automatic void model_reset();
        for (int i = 0; i < 39; i++) mem[i] = '0;
        stg = '0; jt = '0; done_m = 0; pend = 0; have_run = 0; S = 0; snap = '0;
    endfunction

    // retire a run once its capture edge (S+2+RC) has passed
    function automatic void upd(input int x);
        if (pend && x >= S + 2 + RC) begin
            for (int j = 0; j < 6; j++) begin
                mem[33+j] = snap[j];
`ifdef IK_SWIFT_BRIDGE_DH_UPDATE_EN
                mem[j*4 + (jt[j] ? 1 : 0)] = mem[j*4 + (jt[j] ? 1 : 0)] + snap[j];
`endif
            end
            done_m = 1; pend = 0;
        end
    endfunction

    function automatic bit busy_m(input int x);
        return pend && x >= S && x <= S + 1 + RC;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // one bus cycle; called at posedge+1, sampled by the DUT at edge ecnt+1
    task automatic op(input bit w_, input bit r_, input logic [6:0] a, input logic [31:0] d);
        bit b;
        int wi;
        logic [31:0] e;
        upd(ecnt);
        b  = busy_m(ecnt);
        wi = int'(a) / 2;
        if (r_) begin
            e = '0;
            if (a < 7'd78) e = a[0] ? {28'b0, mem[wi][35:32]} : mem[wi][31:0];
            else if (a == 7'd81) e = {30'b0, done_m, b};
            else if (a == 7'd82) e = {26'b0, jt};
            expq.push_back(e);
        end
        if (w_) begin
            if (a < 7'd78) begin
                if (!b && wi < 33) begin
                    if (!a[0]) stg = d;
                    else mem[wi] = {d[3:0], stg};
                end
            end else if (a == 7'd80) begin
                if (d[1]) done_m = 0;
                if (d[0] && !b) begin
                    done_m = 0; pend = 1; have_run = 1; S = ecnt + 1; snap = delta_tb;
                end
            end else if (a == 7'd82 && !b) begin
                jt = d[5:0];
            end
        end
        cs = 1; wr = w_; rd = r_; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 0; wr = 0; rd = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_outs();
        upd(ecnt);
        chk("joint_type", joint_type, jt);
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("dh_param[%0d][%0d]", j, k), dh_param[j][k], mem[j*4+k]);
            chk($sformatf("target[%0d]", j), target[j], mem[24+j]);
        end
        for (int i = 0; i < 3; i++) chk($sformatf("z[%0d]", i), z[i], mem[30+i]);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rdv) begin
            if (expq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL readdata: unexpected read response %0h", readdata);
            end else begin
                chk("readdata", readdata, expq.pop_front());
            end
        end
        if (rst_n && have_run) begin
            chk("core_rst window", core_rst, ecnt == S);
            chk("core_en window", core_en, (ecnt >= S + 1) && (ecnt <= S + RC));
        end
        if (core_en) en_cnt++;
        if (core_rst) rst_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset readdata", readdata, 0);
        chk("reset core_en", core_en, 0);
        chk("reset core_rst", core_rst, 0);
        rst_n = 1;
        idle(1);

        // reset-state reads
        op(0, 1, 7'd0, 0); op(0, 1, 7'd1, 0); op(0, 1, 7'd66, 0); op(0, 1, 7'd81, 0);
        check_outs();

        // staged 36-bit load of target[0]
        op(1, 0, 7'd48, 32'hDEADBEEF);
        check_outs();
        chk("target0 after LO only", target[0], 36'h0);
        op(1, 0, 7'd49, 32'h00000005);
        check_outs();
        chk("target0 committed", target[0], 36'h5DEADBEEF);
        op(0, 1, 7'd48, 0); op(0, 1, 7'd49, 0);

        // directed run with blocked writes, ignored restart and clear while busy
        for (int j = 0; j < 6; j++) delta_tb[j] = {$urandom, $urandom} & 36'hFFFFFFFFF;
        delta_tb[2] = 36'h0_0000_0010;
        idle(1);
        en_cnt = 0; rst_cnt = 0;
        op(1, 0, 7'd80, 32'h1);
        op(1, 0, 7'd0, 32'h12345678);
        op(1, 0, 7'd1, 32'h9);
        op(1, 0, 7'd80, 32'h1);
        op(0, 1, 7'd81, 0);
        op(1, 0, 7'd80, 32'h2);
        idle(RC + 2);
        op(0, 1, 7'd81, 0);
        op(0, 1, 7'd70, 0);
        op(0, 1, 7'd71, 0);
        chk("core_en cycles for one run", en_cnt, RC);
        chk("core_rst cycles for one run", rst_cnt, 1);
        check_outs();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r, wsel;
            upd(ecnt);
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin
                    wsel = $urandom_range(0, 32);
                    if (!busy_m(ecnt)) op(1, 0, 7'(2*wsel), $urandom);
                    else idle(1);
                end
                2, 3: begin
                    wsel = $urandom_range(0, 38);
                    op(1, 0, 7'(2*wsel+1), $urandom);
                end
                4, 5: op(0, 1, 7'($urandom_range(0, 127)), 0);
                6:    op(1, 0, 7'd80, $urandom);
                7:    op(1, 0, 7'd82, $urandom);
                8:    op(1, 0, 7'($urandom_range(78, 127)), $urandom);
                default: begin
                    if (!pend)
                        for (int j = 0; j < 6; j++) delta_tb[j] = {$urandom, $urandom} & 36'hFFFFFFFFF;
                    idle(1);
                    check_outs();
                end
            endcase
        end
        idle(RC + 4);
        for (int a = 66; a < 84; a++) op(0, 1, 7'(a), 0);
        check_outs();

        // asynchronous reset in the middle of RUN
        op(1, 0, 7'd80, 32'h1);
        while (ecnt < S + 3) idle(1);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("core_en after async reset", core_en, 0);
        chk("core_rst after async reset", core_rst, 0);
        check_outs();
        @(posedge clk); #1 rst_n = 1;
        idle(1);
        op(0, 1, 7'd81, 0); op(0, 1, 7'd48, 0); op(0, 1, 7'd70, 0);

        // closed-loop DH update (or its absence in the default build)
        op(1, 0, 7'd82, 32'h02);
        op(1, 0, 7'd10, 32'hFFFFFFFF); op(1, 0, 7'd11, 32'hF);
        op(1, 0, 7'd0, 32'h00000100);  op(1, 0, 7'd1, 32'h0);
        delta_tb = '0;
        delta_tb[1] = 36'd1;
        delta_tb[0] = 36'h0_0000_0023;
        op(1, 0, 7'd80, 32'h1);
        idle(RC + 3);
        check_outs();
`ifdef IK_SWIFT_BRIDGE_DH_UPDATE_EN
        chk("dh[1][1] wrapped", dh_param[1][1], 36'h0);
        chk("dh[0][0] updated", dh_param[0][0], 36'h123);
`else
        chk("dh[1][1] untouched", dh_param[1][1], 36'hFFFFFFFFF);
        chk("dh[0][0] untouched", dh_param[0][0], 36'h100);
`endif
        op(0, 1, 7'd81, 0); op(0, 1, 7'd68, 0);

        idle(2);
        chk("scoreboard drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
